// File: rtl/clk_rate_gen_pkg.sv
// clk_rate_pkg: divisor constants, debounce length and speed-select encoding for clk_rate_gen.
package clk_rate_pkg;
   localparam int DIV_25M      = 10;
   localparam int DIV_2M       = 125;
   localparam int DIV_31K      = 8000;
   localparam int DIV_250      = 125;
   localparam int DEBOUNCE_CYC = 2500000;
   typedef enum logic [1:0] {
      SEL_250HZ = 2'b00,
      SEL_25M   = 2'b01,
      SEL_31K   = 2'b10,
      SEL_2M    = 2'b11
   } speed_sel_t;
endpackage

// File: rtl/clk_rate_gen_div_ch.sv
// clk_div_ch: enable-gated divide-by-N square wave, high for floor(N/2) enabled cycles, plus registered wrap pulse.
module clk_div_ch #(
   parameter int N = 10
) (
   input  logic pll0_250MHz,
   input  logic reset,
   input  logic en,
   output logic out,
   output logic wrap
);
   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] HALF = W'(N / 2);
   localparam logic [W-1:0] LAST = W'(N - 1);
   logic [W-1:0] cnt;
   always_ff @(posedge pll0_250MHz) begin
      if (reset) begin
         cnt  <= '0;
         out  <= 1'b0;
         wrap <= 1'b0;
      end else begin
         wrap <= en && (cnt == LAST);
         if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            out <= cnt < HALF;
         end
      end
   end
endmodule

// File: rtl/clk_rate_gen.sv
// clk_rate_gen: CPU source clocks (25M/2M/31.25k/250Hz) and conditioned speed-select switches.
// Define SW_DEBOUNCE_EN to add the switch debounce counter; otherwise sw follows the synchroniser.
module clk_rate_gen
   import clk_rate_pkg::*;
#(
   parameter int DIV_25M_P = DIV_25M,
   parameter int DIV_2M_P  = DIV_2M,
   parameter int DIV_31K_P = DIV_31K,
   parameter int DIV_250_P = DIV_250
) (
   input  logic       pll0_250MHz,
   input  logic       reset,
   input  logic [1:0] sw_raw,
   output logic       MHz25,
   output logic       MHz2,
   output logic       KHz31,
   output logic       Hz250,
   output logic       tick31k,
   output speed_sel_t sw,
   output logic       sw_chg
);
   logic [1:0] s1, sw_s;
   logic [2:0] unused_wrap;
   clk_div_ch #(.N(DIV_25M_P)) u_25m (
      .pll0_250MHz(pll0_250MHz), .reset(reset), .en(1'b1), .out(MHz25), .wrap(unused_wrap[0])
   );
   clk_div_ch #(.N(DIV_2M_P)) u_2m (
      .pll0_250MHz(pll0_250MHz), .reset(reset), .en(1'b1), .out(MHz2), .wrap(unused_wrap[1])
   );
   clk_div_ch #(.N(DIV_31K_P)) u_31k (
      .pll0_250MHz(pll0_250MHz), .reset(reset), .en(1'b1), .out(KHz31), .wrap(tick31k)
   );
   // 250 Hz is cascaded off the 31.25 kHz tick to keep its counter narrow
   clk_div_ch #(.N(DIV_250_P)) u_250 (
      .pll0_250MHz(pll0_250MHz), .reset(reset), .en(tick31k), .out(Hz250), .wrap(unused_wrap[2])
   );
   always_ff @(posedge pll0_250MHz) begin
      if (reset) begin
         s1   <= SEL_2M;
         sw_s <= SEL_2M;
      end else begin
         s1   <= sw_raw;
         sw_s <= s1;
      end
   end
`ifdef SW_DEBOUNCE_EN
   localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
   logic [DW-1:0] db_cnt;
   // any return of sw_s to the accepted value restarts the stability window
   always_ff @(posedge pll0_250MHz) begin
      if (reset) begin
         db_cnt <= '0;
         sw     <= SEL_2M;
         sw_chg <= 1'b0;
      end else begin
         sw_chg <= 1'b0;
         if (sw_s == sw) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            sw     <= speed_sel_t'(sw_s);
            sw_chg <= 1'b1;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end
`else
   always_ff @(posedge pll0_250MHz) begin
      if (reset) begin
         sw     <= SEL_2M;
         sw_chg <= 1'b0;
      end else begin
         sw     <= speed_sel_t'(sw_s);
         sw_chg <= sw_s != sw;
      end
   end
`endif
endmodule

// File: tb/tb_clk_rate_gen.sv
// tb_clk_rate_gen: directed checks of divider waveforms, cascade tick, switch path and mid-run reset.
module tb_clk_rate_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sw_raw = 2'b11;
   logic       mhz25, mhz2, khz31, hz250, tick, chg;
   logic [1:0] sw;
   int total = 0, bad = 0, k = 0;
   int e25, e2, e31, etk, ehz, hi2, hi31, ntick, nchg;
   int tick_at [2];

   always #2 clk = ~clk;

   clk_rate_gen dut (
      .pll0_250MHz(clk), .reset(rst), .sw_raw(sw_raw),
      .MHz25(mhz25), .MHz2(mhz2), .KHz31(khz31), .Hz250(hz250),
      .tick31k(tick), .sw(sw), .sw_chg(chg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      e25 = 0; e2 = 0; e31 = 0; etk = 0; ehz = 0;
      hi2 = 0; hi31 = 0; ntick = 0; nchg = 0;
      tick_at[0] = -1; tick_at[1] = -1;
   endtask

   // k = edges since reset release; expected waveforms in closed form (valid for k < 504001)
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         k++;
         e25 += int'(mhz25 !== ((k - 1) % 10 < 5));
         e2  += int'(mhz2  !== ((k - 1) % 125 < 62));
         e31 += int'(khz31 !== ((k - 1) % 8000 < 4000));
         etk += int'(tick  !== (k % 8000 == 0));
         ehz += int'(hz250 !== (k >= 8001));
         hi2  += int'(mhz2 === 1'b1);
         hi31 += int'(khz31 === 1'b1);
         nchg += int'(chg === 1'b1);
         if (tick === 1'b1) begin
            if (ntick < 2) tick_at[ntick] = k;
            ntick++;
         end
      end
   endtask

   initial begin
      clr();
      repeat (5) cyc();
      chk("rst_mhz25", mhz25, 0);
      chk("rst_mhz2", mhz2, 0);
      chk("rst_khz31", khz31, 0);
      chk("rst_hz250", hz250, 0);
      chk("rst_tick", tick, 0);
      chk("rst_chg", chg, 0);
      chk("rst_sw", sw, 3);
      rst = 1'b0;
      k = 0;
      run(1);
      chk("mhz25_edge1", mhz25, 1);
      run(999);
      chk("mhz25_wave", e25, 0);
      chk("mhz2_wave", e2, 0);
      chk("mhz2_high_1000", hi2, 496);
      sw_raw = 2'b01;
      run(2);
      chk("sw_hold_2cyc", sw, 3);
      run(1);
`ifndef SW_DEBOUNCE_EN
      chk("sw_lat3", sw, 1);
      chk("chg_pulse", chg, 1);
      run(1);
      chk("chg_single", chg, 0);
      run(496);
      sw_raw = 2'b11;
      run(3);
      chk("glitch_follow", sw, 3);
      run(997);
      sw_raw = 2'b01;
      run(3);
      chk("settle_follow", sw, 1);
      chk("chg_count", nchg, 3);
`else
      run(1500);
      sw_raw = 2'b11;
      run(3);
      sw_raw = 2'b01;
      run(997);
      chk("sw_debounced_hold", sw, 3);
      chk("chg_count", nchg, 0);
`endif
      run(16000 - k);
      chk("mhz25_wave_16k", e25, 0);
      chk("mhz2_wave_16k", e2, 0);
      chk("khz31_wave", e31, 0);
      chk("khz31_high_16k", hi31, 8000);
      chk("tick_wave", etk, 0);
      chk("tick_count", ntick, 2);
      chk("tick_first", tick_at[0], 8000);
      chk("tick_second", tick_at[1], 16000);
      chk("hz250_wave", ehz, 0);
      chk("hz250_high", hz250, 1);
      sw_raw = 2'b11;
      while (k % 125 != 40) run(1);
      chk("pre_rst_mhz2", mhz2, 1);
      rst = 1'b1;
      cyc();
      chk("mid_rst_mhz25", mhz25, 0);
      chk("mid_rst_mhz2", mhz2, 0);
      chk("mid_rst_khz31", khz31, 0);
      chk("mid_rst_hz250", hz250, 0);
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_sw", sw, 3);
      rst = 1'b0;
      k = 0;
      clr();
      run(1000);
      chk("restart_mhz25", e25, 0);
      chk("restart_mhz2", e2, 0);
      chk("restart_khz31", e31, 0);
      chk("restart_hz250", ehz, 0);
      chk("restart_mhz2_high", hi2, 496);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
